// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake status and memory-arbiter FSM states.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // ACCESS and ERROR both end the RAM transaction.
  function automatic logic ram_ends(ramstate_t rs);
    return (rs == ACCESS) || (rs == ERROR);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and data access.
// Build option MEM_ARB_FAIRNESS_EN bounds consecutive data grants while fetch waits.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MAX_D_STREAK   = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        bus_err
);

  arb_state_t  state_q, state_d;
  logic [31:0] tmo_q, tmo_d;
  logic        bus_err_q, err_set;
  logic        ireq, dreq;
  logic        i_done, d_done;
  logic        force_i;
  ramstate_t   rs;

  assign ireq = iREN;
  assign dreq = dREN | dWEN;
  assign rs   = ramstate_t'(ramstate);

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    err_set  = 1'b0;
    i_done   = 1'b0;
    d_done   = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (dreq && !force_i) begin
          state_d = D_ACC;
        end else if (ireq) begin
          state_d = I_ACC;
        end
      end
      D_ACC: begin
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dreq) begin
          state_d = IDLE;
          tmo_d   = '0;
        end else begin
          ramWEN = dWEN;
          ramREN = dREN & ~dWEN;
          if (ram_ends(rs) || (tmo_q == TIMEOUT_CYCLES - 1)) begin
            d_done  = 1'b1;
            err_set = (rs != ACCESS);
            dload   = (rs == ACCESS) ? ramload : '0;
            state_d = DONE;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + 32'd1;
          end
        end
      end
      I_ACC: begin
        ramaddr = iaddr;
        if (!ireq) begin
          state_d = IDLE;
          tmo_d   = '0;
        end else begin
          ramREN = 1'b1;
          if (ram_ends(rs) || (tmo_q == TIMEOUT_CYCLES - 1)) begin
            i_done  = 1'b1;
            err_set = (rs != ACCESS);
            iload   = (rs == ACCESS) ? ramload : '0;
            state_d = DONE;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + 32'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        tmo_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign iwait   = ireq & ~i_done;
  assign dwait   = dreq & ~d_done;
  assign bus_err = bus_err_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      bus_err_q <= bus_err_q | err_set;
    end
  end

`ifdef MEM_ARB_FAIRNESS_EN
  logic [31:0] streak_q, streak_d;

  assign force_i = ireq && (streak_q >= MAX_D_STREAK);

  always_comb begin
    streak_d = streak_q;
    if (state_q == IDLE) begin
      if (dreq && !force_i) begin
        if (ireq && (streak_q < MAX_D_STREAK)) streak_d = streak_q + 32'd1;
      end else if (ireq) begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  // Strict data priority: fetch is never forced ahead of a data request.
  assign force_i = (MAX_D_STREAK == 0) && 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with hand-written timeout and fairness sequences.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN, bus_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(
    .TIMEOUT_CYCLES(8),
    .MAX_D_STREAK  (4)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iload   (iload),
    .iwait   (iwait),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dload   (dload),
    .dwait   (dwait),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate),
    .bus_err (bus_err)
  );

  typedef struct {
    logic        nrst, iren, dren, dwen;
    logic [31:0] ia, da, ds, rl;
    logic [1:0]  rs;
    logic        e_iw, e_dw, e_ren, e_wen;
    logic [31:0] e_addr, e_store, e_il, e_dl;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic nrst, logic iren, logic dren, logic dwen,
                              logic [31:0] ia, logic [31:0] da, logic [31:0] ds,
                              logic [31:0] rl, logic [1:0] rs,
                              logic e_iw, logic e_dw, logic e_ren, logic e_wen,
                              logic [31:0] e_addr, logic [31:0] e_store,
                              logic [31:0] e_il, logic [31:0] e_dl, logic e_err);
    vec_t v;
    v.nrst = nrst; v.iren = iren; v.dren = dren; v.dwen = dwen;
    v.ia = ia; v.da = da; v.ds = ds; v.rl = rl; v.rs = rs;
    v.e_iw = e_iw; v.e_dw = e_dw; v.e_ren = e_ren; v.e_wen = e_wen;
    v.e_addr = e_addr; v.e_store = e_store; v.e_il = e_il; v.e_dl = e_dl;
    v.e_err = e_err;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic nrst, logic iren, logic dren, logic dwen, logic [31:0] ia,
                       logic [31:0] da, logic [31:0] ds, logic [31:0] rl, logic [1:0] rs);
    @(negedge CLK);
    nRST = nrst; iREN = iren; dREN = dren; dWEN = dwen;
    iaddr = ia; daddr = da; dstore = ds; ramload = rl; ramstate = rs;
    #1;
  endtask

  localparam logic [1:0] F = 2'd0, B = 2'd1, A = 2'd2, E = 2'd3;

  initial begin
    logic [31:0] exp_addr;
    string       tag;

    drive(0, 0, 0, 0, 0, 0, 0, 0, F);
    drive(0, 0, 0, 0, 0, 0, 0, 0, F);

    // Reset state
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,F,                          0,0,0,0, 0,0,0,0, 0));
    // Instruction only
    vecs.push_back(mk(1,1,0,0, 32'h40,0,0,0,F,                     1,0,0,0, 0,0,0,0, 0));
    vecs.push_back(mk(1,1,0,0, 32'h40,0,0,32'h2108000A,A,          0,0,1,0, 32'h40,0,32'h2108000A,0, 0));
    vecs.push_back(mk(1,0,0,0, 32'h44,0,0,0,F,                     0,0,0,0, 0,0,0,0, 0));
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,F,                          0,0,0,0, 0,0,0,0, 0));
    // Contention: data wins, fetch waits through data access and DONE
    vecs.push_back(mk(1,1,0,1, 32'h44,32'h80,32'hDEADBEEF,0,F,     1,1,0,0, 0,0,0,0, 0));
    vecs.push_back(mk(1,1,0,1, 32'h44,32'h80,32'hDEADBEEF,0,A,     1,0,0,1, 32'h80,32'hDEADBEEF,0,0, 0));
    vecs.push_back(mk(1,1,0,0, 32'h44,32'h80,32'hDEADBEEF,0,F,     1,0,0,0, 0,0,0,0, 0));
    vecs.push_back(mk(1,1,0,0, 32'h44,0,0,0,F,                     1,0,0,0, 0,0,0,0, 0));
    vecs.push_back(mk(1,1,0,0, 32'h44,0,0,32'h12345678,A,          0,0,1,0, 32'h44,0,32'h12345678,0, 0));
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,F,                          0,0,0,0, 0,0,0,0, 0));
    // RAM latency: three BUSY cycles then ACCESS
    vecs.push_back(mk(1,0,1,0, 0,32'h100,0,0,F,                    0,1,0,0, 0,0,0,0, 0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1,0,1,0, 0,32'h100,0,0,B,                  0,1,1,0, 32'h100,0,0,0, 0));
    vecs.push_back(mk(1,0,1,0, 0,32'h100,0,32'hCAFEF00D,A,         0,0,1,0, 32'h100,0,0,32'hCAFEF00D, 0));
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,F,                          0,0,0,0, 0,0,0,0, 0));
    // Withdrawn data request returns straight to IDLE
    vecs.push_back(mk(1,0,1,0, 0,32'h200,0,0,F,                    0,1,0,0, 0,0,0,0, 0));
    vecs.push_back(mk(1,0,0,0, 0,32'h200,0,0,B,                    0,0,0,0, 32'h200,0,0,0, 0));
    vecs.push_back(mk(1,1,0,0, 32'h48,0,0,0,F,                     1,0,0,0, 0,0,0,0, 0));
    vecs.push_back(mk(1,1,0,0, 32'h48,0,0,32'h0BADCAFE,A,          0,0,1,0, 32'h48,0,32'h0BADCAFE,0, 0));
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,F,                          0,0,0,0, 0,0,0,0, 0));
    // ERROR on a read, then reset mid I_ACC
    vecs.push_back(mk(1,0,1,0, 0,32'h300,0,0,F,                    0,1,0,0, 0,0,0,0, 0));
    vecs.push_back(mk(1,0,1,0, 0,32'h300,0,32'hFFFFFFFF,E,         0,0,1,0, 32'h300,0,0,0, 0));
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,F,                          0,0,0,0, 0,0,0,0, 1));
    vecs.push_back(mk(1,1,0,0, 32'h50,0,0,0,F,                     1,0,0,0, 0,0,0,0, 1));
    vecs.push_back(mk(1,1,0,0, 32'h50,0,0,0,B,                     1,0,1,0, 32'h50,0,0,0, 1));
    vecs.push_back(mk(0,1,0,0, 32'h50,0,0,0,B,                     1,0,1,0, 32'h50,0,0,0, 1));
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,B,                          0,0,0,0, 0,0,0,0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].nrst, vecs[i].iren, vecs[i].dren, vecs[i].dwen, vecs[i].ia,
            vecs[i].da, vecs[i].ds, vecs[i].rl, vecs[i].rs);
      check($sformatf("v%0d iwait", i),    32'(iwait),   32'(vecs[i].e_iw));
      check($sformatf("v%0d dwait", i),    32'(dwait),   32'(vecs[i].e_dw));
      check($sformatf("v%0d ramREN", i),   32'(ramREN),  32'(vecs[i].e_ren));
      check($sformatf("v%0d ramWEN", i),   32'(ramWEN),  32'(vecs[i].e_wen));
      check($sformatf("v%0d ramaddr", i),  ramaddr,      vecs[i].e_addr);
      check($sformatf("v%0d ramstore", i), ramstore,     vecs[i].e_store);
      check($sformatf("v%0d iload", i),    iload,        vecs[i].e_il);
      check($sformatf("v%0d dload", i),    dload,        vecs[i].e_dl);
      check($sformatf("v%0d bus_err", i),  32'(bus_err), 32'(vecs[i].e_err));
    end

    // Timeout: RAM stays BUSY, eighth ACC cycle force-completes
    drive(1, 0, 1, 0, 0, 32'h400, 0, 32'hAAAA5555, B);
    check("tmo idle dwait", 32'(dwait), 32'd1);
    check("tmo idle ramREN", 32'(ramREN), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      drive(1, 0, 1, 0, 0, 32'h400, 0, 32'hAAAA5555, B);
      tag = $sformatf("tmo acc%0d", k);
      check({tag, " ramREN"}, 32'(ramREN), 32'd1);
      check({tag, " dwait"}, 32'(dwait), (k == 8) ? 32'd0 : 32'd1);
      check({tag, " bus_err"}, 32'(bus_err), 32'd0);
      if (k == 8) check({tag, " dload"}, dload, 32'd0);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, B);
    check("tmo done bus_err", 32'(bus_err), 32'd1);
    check("tmo done ramREN", 32'(ramREN), 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, F);
      check($sformatf("tmo sticky%0d", k), 32'(bus_err), 32'd1);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, F);
    drive(1, 0, 0, 0, 0, 0, 0, 0, F);
    check("tmo reset bus_err", 32'(bus_err), 32'd0);

    // Fairness: both requesters held high, RAM answers immediately
    for (int g = 0; g < 6; g++) begin
      drive(1, 1, 1, 0, 32'h60, 32'h70, 0, 0, A);
      drive(1, 1, 1, 0, 32'h60, 32'h70, 0, 0, A);
`ifdef MEM_ARB_FAIRNESS_EN
      exp_addr = (g == 4) ? 32'h60 : 32'h70;
`else
      exp_addr = 32'h70;
`endif
      check($sformatf("grant%0d ramaddr", g), ramaddr, exp_addr);
      check($sformatf("grant%0d ramREN", g), 32'(ramREN), 32'd1);
      drive(1, 1, 1, 0, 32'h60, 32'h70, 0, 0, A);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
